// File: rtl/fwd_pkg.sv
// Shared stage-entry type, forwarding-select encoding and parameter range limits
// for the forward scoreboard.
package fwd_pkg;

  localparam int RD_W        = 8;
  localparam int REG_AW_MAX  = RD_W;
  localparam int NUM_SRC_MIN = 1;
  localparam int NUM_SRC_MAX = 4;
  localparam int DEPTH_MIN   = 1;
  localparam int DEPTH_MAX   = 4;

  // fwd_sel value meaning "read the register file"; k>0 means stage k.
  localparam int FWD_SEL_RF  = 0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

endpackage

// File: rtl/fwd_match.sv
// Nearest-stage match for one source operand; purely combinational.
// Reports the youngest matching stage and whether that hit is a load sitting in stage 1.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic [DEPTH*STAGE_W-1:0] stages,
  input  logic [REG_AW-1:0]        src_addr,
  output logic [SEL_W-1:0]         sel,
  output logic                     load_hit
);

  stage_t [DEPTH-1:0] st;
  assign st = stages;

  // Scan oldest to youngest so the nearest stage overwrites any older hit.
  always_comb begin
    sel      = SEL_W'(FWD_SEL_RF);
    load_hit = 1'b0;
    if (src_addr != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (st[k].valid && (st[k].rd == RD_W'(src_addr))) begin
          sel      = SEL_W'(k + 1);
          load_hit = (k == 0) && st[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destinations, selects bypass stage, flags load-use.
// Outputs combinational from state (issue lands in stage 1 next edge); hold freezes, flush clears.
// Optional counters stat_fwd_cnt/stat_stall_cnt under FWD_SCOREBOARD_STATS_EN.
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 2,
  parameter  int REG_AW  = 5,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid,
  input  logic [REG_AW-1:0]                issue_rd,
  input  logic                             issue_regwrite,
  input  logic                             issue_is_load,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]               src_used,
  input  logic                             hold,
  input  logic                             flush,
  output logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel,
  output logic                             stall_out
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                      stat_fwd_cnt,
  output logic [31:0]                      stat_stall_cnt
`endif
);

  if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX ||
      DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || REG_AW > REG_AW_MAX) begin : g_bad_param
    $error("forward_scoreboard: parameter out of range");
  end

  stage_t [DEPTH-1:0]            stage_q;
  stage_t                        stage_in;
  logic   [NUM_SRC-1:0][SEL_W-1:0] sel_raw;
  logic   [NUM_SRC-1:0]          load_hit;

  // A stalled instruction does not enter the pipe; stage 1 takes a bubble instead.
  always_comb begin
    stage_in         = '0;
    stage_in.valid   = issue_valid & issue_regwrite & (issue_rd != '0) & ~stall_out;
    stage_in.rd      = RD_W'(issue_rd);
    stage_in.is_load = issue_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k].valid <= 1'b0;
      end
    end else if (!hold) begin
      stage_q[0] <= stage_in;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .DEPTH  (DEPTH),
      .REG_AW (REG_AW),
      .SEL_W  (SEL_W)
    ) u_match (
      .stages   (stage_q),
      .src_addr (src_addr[i]),
      .sel      (sel_raw[i]),
      .load_hit (load_hit[i])
    );
  end

  assign fwd_sel   = issue_valid ? sel_raw : '0;
  assign stall_out = issue_valid & (|(load_hit & src_used));

`ifdef FWD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if ((|fwd_sel) && (stat_fwd_cnt != '1)) begin
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
      if (stall_out && (stat_stall_cnt != '1)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed scenarios plus randomized traffic
// against a queue-based model of in-flight producers.
module tb_forward_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int REG_AW  = 5;
  localparam int SEL_W   = $clog2(DEPTH + 1);

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           issue_valid = 1'b0;
  logic [REG_AW-1:0]              issue_rd = '0;
  logic                           issue_regwrite = 1'b0;
  logic                           issue_is_load = 1'b0;
  logic [NUM_SRC-1:0][REG_AW-1:0] src_addr = '0;
  logic [NUM_SRC-1:0]             src_used = '0;
  logic                           hold = 1'b0;
  logic                           flush = 1'b0;
  logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel;
  logic                           stall_out;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0]                    stat_fwd_cnt;
  logic [31:0]                    stat_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  forward_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .REG_AW  (REG_AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .hold           (hold),
    .flush          (flush),
    .fwd_sel        (fwd_sel),
    .stall_out      (stall_out)
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    .stat_fwd_cnt   (stat_fwd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // Model: list of accepted producers, youngest first, at most DEPTH long.
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ent_t;

  ent_t q[$];
  int   exp_fwd   = 0;
  int   exp_stall = 0;

  function automatic int m_sel(int i);
    if (!issue_valid || src_addr[i] == 0) return 0;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].v && q[k].rd == int'(src_addr[i])) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_stall();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && m_sel(i) == 1 && q[0].ld) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_any_fwd();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_sel(i) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    bit   st;
    bit   af;
    ent_t e;
    st = m_stall();
    af = m_any_fwd();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_fwd   = 0;
      exp_stall = 0;
    end else begin
      if (af) exp_fwd++;
      if (st) exp_stall++;
      if (flush) begin
        q.delete();
      end else if (!hold) begin
        e.v  = issue_valid && issue_regwrite && issue_rd != 0 && !st;
        e.rd = int'(issue_rd);
        e.ld = issue_is_load;
        q.push_front(e);
        if (q.size() > DEPTH) void'(q.pop_back());
      end
    end
    #1;
  endtask

  task automatic set_issue(bit v, int rd, bit rw, bit ld);
    issue_valid    = v;
    issue_rd       = REG_AW'(rd);
    issue_regwrite = rw;
    issue_is_load  = ld;
  endtask

  task automatic set_src(int i, int a, bit u);
    src_addr[i] = REG_AW'(a);
    src_used[i] = u;
  endtask

  task automatic idle();
    set_issue(0, 0, 0, 0);
    src_addr = '0;
    src_used = '0;
    hold     = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic clear_pipe();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_issue(1, 5, 1, 1);
    set_src(0, 5, 1);
    #2;
    checks++;
    if (fwd_sel !== '0) begin
      errors++;
      $display("FAIL reset_fwd_sel got=%0h exp=0", fwd_sel);
    end
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%0b exp=0", stall_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    #1;
  endtask

  task automatic test_back_to_back();
    clear_pipe();
    set_issue(1, 5, 1, 0);
    tick();
    set_issue(1, 10, 1, 0);
    set_src(0, 5, 1);
    #1;
    checks++;
    if (fwd_sel[0] !== SEL_W'(1)) begin
      errors++;
      $display("FAIL b2b_sel_stage1 got=%0d exp=1", fwd_sel[0]);
    end
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall got=%0b exp=0", stall_out);
    end
    tick();
    set_issue(1, 0, 0, 0);
    #1;
    checks++;
    if (fwd_sel[0] !== SEL_W'(2)) begin
      errors++;
      $display("FAIL b2b_sel_stage2 got=%0d exp=2", fwd_sel[0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_pipe();
    set_issue(1, 7, 1, 1);
    tick();
    set_issue(1, 11, 1, 0);
    set_src(1, 7, 1);
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got=%0b exp=1", stall_out);
    end
    tick();
    checks++;
    if (stall_out !== 1'b0 || fwd_sel[1] !== SEL_W'(2)) begin
      errors++;
      $display("FAIL load_use_after got stall=%0b sel=%0d exp stall=0 sel=2", stall_out, fwd_sel[1]);
    end
    tick();
    clear_pipe();
    set_issue(1, 7, 1, 1);
    tick();
    set_issue(1, 11, 1, 0);
    set_src(1, 7, 0);
    #1;
    checks++;
    if (stall_out !== 1'b0 || fwd_sel[1] !== SEL_W'(1)) begin
      errors++;
      $display("FAIL load_unused got stall=%0b sel=%0d exp stall=0 sel=1", stall_out, fwd_sel[1]);
    end
    tick();
  endtask

  task automatic test_priority();
    clear_pipe();
    set_issue(1, 3, 1, 0);
    tick();
    tick();
    set_issue(1, 0, 0, 0);
    set_src(0, 3, 1);
    #1;
    checks++;
    if (fwd_sel[0] !== SEL_W'(1)) begin
      errors++;
      $display("FAIL priority_nearest got=%0d exp=1", fwd_sel[0]);
    end
    clear_pipe();
    set_issue(1, 0, 1, 1);
    tick();
    set_issue(1, 0, 0, 0);
    set_src(0, 0, 1);
    set_src(1, 0, 1);
    #1;
    checks++;
    if (fwd_sel !== '0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_fwd got sel=%0h stall=%0b exp sel=0 stall=0", fwd_sel, stall_out);
    end
    tick();
  endtask

  task automatic test_hold_flush();
    clear_pipe();
    set_issue(1, 9, 1, 0);
    tick();
    set_issue(1, 0, 0, 0);
    set_src(0, 9, 1);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (fwd_sel[0] !== SEL_W'(1)) begin
        errors++;
        $display("FAIL hold_cycle%0d got=%0d exp=1", c, fwd_sel[0]);
      end
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    hold  = 1'b0;
    #1;
    checks++;
    if (fwd_sel !== '0) begin
      errors++;
      $display("FAIL flush_with_hold got=%0h exp=0", fwd_sel);
    end
  endtask

  task automatic test_reset_mid();
    clear_pipe();
    set_issue(1, 4, 1, 0);
    tick();
    set_issue(1, 12, 1, 0);
    tick();
    set_issue(1, 0, 0, 0);
    set_src(0, 4, 1);
    #1;
    checks++;
    if (fwd_sel[0] !== SEL_W'(2)) begin
      errors++;
      $display("FAIL pre_reset_sel got=%0d exp=2", fwd_sel[0]);
    end
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (fwd_sel !== '0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got sel=%0h stall=%0b exp 0/0", fwd_sel, stall_out);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (fwd_sel[0] !== SEL_W'(0)) begin
      errors++;
      $display("FAIL post_reset_sel got=%0d exp=0", fwd_sel[0]);
    end
    tick();
  endtask

`ifdef FWD_SCOREBOARD_STATS_EN
  task automatic test_stats();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    set_issue(1, 7, 1, 1);
    tick();
    set_issue(1, 11, 1, 0);
    set_src(1, 7, 1);
    tick();
    tick();
    set_issue(1, 0, 0, 0);
    set_src(0, 11, 1);
    set_src(1, 0, 0);
    tick();
    idle();
    tick();
    checks++;
    if (stat_fwd_cnt !== 32'd3 || stat_stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stats_count got fwd=%0d stall=%0d exp fwd=3 stall=1", stat_fwd_cnt, stat_stall_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int bad = 0;
    clear_pipe();
    for (int n = 0; n < 400; n++) begin
      set_issue(($urandom_range(3) != 0), $urandom_range(7), $urandom_range(1), $urandom_range(1));
      for (int i = 0; i < NUM_SRC; i++) set_src(i, $urandom_range(7), $urandom_range(1));
      hold  = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        checks++;
        if (fwd_sel[i] !== SEL_W'(m_sel(i))) begin
          errors++;
          bad++;
          if (bad < 10) $display("FAIL rand_sel%0d cyc=%0d got=%0d exp=%0d", i, n, fwd_sel[i], m_sel(i));
        end
      end
      checks++;
      if (stall_out !== m_stall()) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL rand_stall cyc=%0d got=%0b exp=%0b", n, stall_out, m_stall());
      end
      tick();
    end
`ifdef FWD_SCOREBOARD_STATS_EN
    checks++;
    if (stat_fwd_cnt !== 32'(exp_fwd) || stat_stall_cnt !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL rand_stats got fwd=%0d stall=%0d exp fwd=%0d stall=%0d",
               stat_fwd_cnt, stat_stall_cnt, exp_fwd, exp_stall);
    end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_hold_flush();
    test_reset_mid();
`ifdef FWD_SCOREBOARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
